spike_readout_controller: RTL and testbench
===========================================

Name: spike_readout_controller

Overview:
- Sequences an array of NUM_ACC spike accumulators through one inference window: clear, gated accumulation for TIMESTEPS timestep ticks, then serial readout of every count over a valid/ready stream.
- Tracks the argmax of the counts during readout and reports the winning class.
- Sits between the accumulator array, the timestep generator, and the downstream result consumer (host interface or FIFO).

Parameters:
- NUM_ACC, 10, number of accumulators (output neurons); must be >= 2.
- DATA_WIDTH, 16, width of each accumulated count.
- TIMESTEPS, 32, step ticks per inference window; must be >= 1.
- IDX_WIDTH, $clog2(NUM_ACC), width of index outputs.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a window; ignored unless state is IDLE.
- step  input  1  single-cycle timestep tick; counted only in ACCUM.
- acc_values  input  NUM_ACC*DATA_WIDTH  flattened counts; accumulator i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- acc_enable  output  1  gates spikes into the accumulator array.
- acc_clear  output  1  one-cycle synchronous clear to the accumulator array.
- busy  output  1  high in every state except IDLE.
- out_valid  output  1  readout beat valid.
- out_ready  input  1  consumer accepts the beat.
- out_index  output  IDX_WIDTH  accumulator index of the current beat.
- out_value  output  DATA_WIDTH  count of the current beat.
- out_last  output  1  high when out_index == NUM_ACC-1 and out_valid is high.
- class_valid  output  1  one-cycle pulse when the argmax result is final.
- class_index  output  IDX_WIDTH  argmax index; held until the next start.
- class_value  output  DATA_WIDTH  argmax count; held until the next start.
- done  output  1  one-cycle pulse at the end of the window.

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs 0, including class_index and class_value. Step counter, read index and argmax registers are cleared. Reset asserted mid-window aborts immediately; no done pulse is produced.
- All outputs are registered. FSM states: IDLE, CLEAR, ACCUM, SETTLE, READOUT, DONE.
- IDLE: start=1 -> CLEAR. class_index and class_value are zeroed on this transition.
- CLEAR (1 cycle): acc_clear=1, acc_enable=0, step is ignored. Step counter is set to 0. Next state is ACCUM.
- ACCUM: acc_enable=1.
  - Each cycle with step=1 increments the step counter (width $clog2(TIMESTEPS+1)).
  - When step=1 and counter==TIMESTEPS-1, go to SETTLE. acc_enable is therefore high through the cycle of the final tick and low from the next cycle.
  - With TIMESTEPS=1, the first tick causes the exit.
- SETTLE (1 cycle): acc_enable=0. This lets the final accumulator update land. On exit, load out_index=0, out_value=acc_values slice 0, out_valid=1.
- READOUT:
  - out_valid stays high. out_index, out_value and out_last must remain stable while out_ready=0.
  - Handshake = out_valid & out_ready.
  - On a handshake with index < NUM_ACC-1: the next cycle presents index+1 and its slice, with no bubble.
  - On a handshake with index == NUM_ACC-1: out_valid=0 next cycle and state goes to DONE.
  - Argmax updates on every handshake. The current value replaces the best only if it is strictly greater, so ties keep the lowest index. Index 0 always initialises the best.
- DONE (1 cycle): done=1, class_valid=1, then IDLE. class_index and class_value persist afterward.
- step outside ACCUM, and start outside IDLE, are ignored.
- out_ready while out_valid=0 has no effect.
- Counts are taken as-is; the controller never saturates or modifies them.
- Window length, from start accepted to done, is 1 (CLEAR) + ACCUM cycles + 1 (SETTLE) + readout beats + 1 (DONE).

Test Plan:
- Basic window (NUM_ACC=4, TIMESTEPS=3):
  - Stimulus: start; drive 3 steps; acc_values={40,7,25,12} for index 3..0; out_ready held at 1.
  - Response: acc_clear one cycle after start; acc_enable low the cycle after the 3rd step; four beats with indices 0..3 on consecutive cycles, out_last on index 3; done and class_valid pulse with class_index=3, class_value=40.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles on beat 1, then 1.
  - Response: out_index=1 and out_value=12 held stable for all 5 cycles; no beat lost or duplicated.
- Tie:
  - Stimulus: counts {9,9,3,9} for index 3..0.
  - Response: class_index=0, class_value=9.
- Ignored inputs:
  - Stimulus: step pulses in IDLE, CLEAR and READOUT; start pulses in ACCUM.
  - Response: step count and window timing unchanged; no restart.
- Reset mid-READOUT:
  - Stimulus: assert rst during beat 2.
  - Response: all outputs 0 asynchronously; no done pulse; a later start runs a clean full window.
- TIMESTEPS=1:
  - Stimulus: one step.
  - Response: acc_enable high for exactly the ACCUM cycles up to and including that tick; readout begins 2 cycles after the tick.

Source files
------------

// File: rtl/spike_readout_controller.sv
// Window sequencer for a spike accumulator array: clear, gated accumulation over
// TIMESTEPS ticks, then a valid/ready readout of every count with argmax tracking.
`timescale 1ns/1ps
module spike_readout_controller #(
   parameter int NUM_ACC    = 10,
   parameter int DATA_WIDTH = 16,
   parameter int TIMESTEPS  = 32,
   parameter int IDX_WIDTH  = $clog2(NUM_ACC)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          step,
   input  logic [NUM_ACC*DATA_WIDTH-1:0] acc_values,
   output logic                          acc_enable,
   output logic                          acc_clear,
   output logic                          busy,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [IDX_WIDTH-1:0]          out_index,
   output logic [DATA_WIDTH-1:0]         out_value,
   output logic                          out_last,
   output logic                          class_valid,
   output logic [IDX_WIDTH-1:0]          class_index,
   output logic [DATA_WIDTH-1:0]         class_value,
   output logic                          done
);

   localparam int CNT_W = $clog2(TIMESTEPS + 1);
   localparam logic [CNT_W-1:0]     LAST_STEP = CNT_W'(TIMESTEPS - 1);
   localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_ACC - 1);

   typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, SETTLE, READOUT, DONE} state_t;

   state_t state, next_state;

   logic [NUM_ACC-1:0][DATA_WIDTH-1:0] acc_arr;
   logic [CNT_W-1:0]      step_cnt;
   logic [IDX_WIDTH-1:0]  best_idx, win_idx, idx_nxt;
   logic [DATA_WIDTH-1:0] best_val, win_val;
   logic                  handshake, take;

   logic                  acc_enable_d, acc_clear_d, busy_d, out_valid_d, out_last_d, done_d;
   logic [IDX_WIDTH-1:0]  out_index_d;
   logic [DATA_WIDTH-1:0] out_value_d;

   assign acc_arr   = acc_values;
   assign handshake = out_valid & out_ready;
   assign idx_nxt   = out_index + IDX_WIDTH'(1);
   // Strictly-greater keeps the lowest index on ties; beat 0 always seeds the best.
   assign take      = (out_index == '0) || (out_value > best_val);
   assign win_idx   = take ? out_index : best_idx;
   assign win_val   = take ? out_value : best_val;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = CLEAR;
         CLEAR:   next_state = ACCUM;
         ACCUM:   if (step && step_cnt == LAST_STEP) next_state = SETTLE;
         SETTLE:  next_state = READOUT;
         READOUT: if (handshake && out_index == LAST_IDX) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Next values of the registered outputs are derived from the upcoming state.
   always_comb begin
      acc_enable_d = (next_state == ACCUM);
      acc_clear_d  = (next_state == CLEAR);
      busy_d       = (next_state != IDLE);
      out_valid_d  = (next_state == READOUT);
      done_d       = (next_state == DONE);
      out_index_d  = out_index;
      out_value_d  = out_value;
      if (state == SETTLE) begin
         out_index_d = '0;
         out_value_d = acc_arr[0];
      end else if (handshake && out_index != LAST_IDX) begin
         out_index_d = idx_nxt;
         out_value_d = acc_arr[idx_nxt];
      end
      out_last_d = out_valid_d && (out_index_d == LAST_IDX);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_enable  <= 1'b0;
         acc_clear   <= 1'b0;
         busy        <= 1'b0;
         out_valid   <= 1'b0;
         out_index   <= '0;
         out_value   <= '0;
         out_last    <= 1'b0;
         class_valid <= 1'b0;
         done        <= 1'b0;
      end else begin
         acc_enable  <= acc_enable_d;
         acc_clear   <= acc_clear_d;
         busy        <= busy_d;
         out_valid   <= out_valid_d;
         out_index   <= out_index_d;
         out_value   <= out_value_d;
         out_last    <= out_last_d;
         class_valid <= done_d;
         done        <= done_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_cnt    <= '0;
         best_idx    <= '0;
         best_val    <= '0;
         class_index <= '0;
         class_value <= '0;
      end else begin
         if (state == CLEAR)
            step_cnt <= '0;
         else if (state == ACCUM && step)
            step_cnt <= step_cnt + CNT_W'(1);

         if (handshake) begin
            best_idx <= win_idx;
            best_val <= win_val;
         end

         if (state == IDLE && start) begin
            class_index <= '0;
            class_value <= '0;
         end else if (handshake && out_index == LAST_IDX) begin
            class_index <= win_idx;
            class_value <= win_val;
         end
      end
   end

endmodule

// File: tb/tb_spike_readout_controller.sv
// Scoreboard bench: stimulus queues expected beats/classes, a negedge monitor pops
// and compares on every handshake and class pulse; a second instance covers TIMESTEPS=1.
`timescale 1ns/1ps
module tb_spike_readout_controller;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Main instance: 4 accumulators, 3 timesteps.
   logic        start = 0, step = 0, out_ready = 0;
   logic [63:0] acc_values = '0;
   logic        acc_enable, acc_clear, busy, out_valid, out_last, class_valid, done;
   logic [1:0]  out_index, class_index;
   logic [15:0] out_value, class_value;

   spike_readout_controller #(.NUM_ACC(4), .DATA_WIDTH(16), .TIMESTEPS(3)) u0 (
      .clk(clk), .rst(rst), .start(start), .step(step), .acc_values(acc_values),
      .acc_enable(acc_enable), .acc_clear(acc_clear), .busy(busy),
      .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
      .out_value(out_value), .out_last(out_last), .class_valid(class_valid),
      .class_index(class_index), .class_value(class_value), .done(done));

   // Second instance: 2 accumulators, single timestep.
   logic        b_start = 0, b_step = 0, b_ready = 0;
   logic [31:0] b_acc = '0;
   logic        b_en, b_clr, b_busy, b_valid, b_last, b_cvalid, b_done;
   logic [0:0]  b_idx, b_cidx;
   logic [15:0] b_val, b_cval;

   spike_readout_controller #(.NUM_ACC(2), .DATA_WIDTH(16), .TIMESTEPS(1)) u1 (
      .clk(clk), .rst(rst), .start(b_start), .step(b_step), .acc_values(b_acc),
      .acc_enable(b_en), .acc_clear(b_clr), .busy(b_busy),
      .out_valid(b_valid), .out_ready(b_ready), .out_index(b_idx),
      .out_value(b_val), .out_last(b_last), .class_valid(b_cvalid),
      .class_index(b_cidx), .class_value(b_cval), .done(b_done));

   typedef struct { logic [1:0] idx; logic [15:0] val; logic last; } beat_t;
   typedef struct { logic [1:0] idx; logic [15:0] val; } cls_t;

   beat_t beat_q[$];
   cls_t  class_q[$];
   int    n_pass = 0, n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares beats and class results as the DUT presents them.
   logic        have_prev = 0;
   logic [1:0]  prev_idx;
   logic [15:0] prev_val;
   logic        prev_last;
   beat_t       exp_b;
   cls_t        exp_c;

   always @(negedge clk) begin
      if (rst) begin
         have_prev = 1'b0;
      end else begin
         if (have_prev) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_index", 32'(out_index), 32'(prev_idx));
            chk("hold_value", 32'(out_value), 32'(prev_val));
            chk("hold_last",  32'(out_last),  32'(prev_last));
         end
         have_prev = out_valid && !out_ready;
         prev_idx  = out_index;
         prev_val  = out_value;
         prev_last = out_last;
         if (out_valid && out_ready) begin
            if (beat_q.size() == 0) chk("beat_outstanding", 32'(beat_q.size()), 32'd1);
            else begin
               exp_b = beat_q.pop_front();
               chk("beat_index", 32'(out_index), 32'(exp_b.idx));
               chk("beat_value", 32'(out_value), 32'(exp_b.val));
               chk("beat_last",  32'(out_last),  32'(exp_b.last));
            end
         end
         if (done || class_valid) begin
            if (class_q.size() == 0) chk("class_outstanding", 32'(class_q.size()), 32'd1);
            else begin
               exp_c = class_q.pop_front();
               chk("done_pulse",   32'(done),        32'd1);
               chk("class_valid",  32'(class_valid), 32'd1);
               chk("class_index",  32'(class_index), 32'(exp_c.idx));
               chk("class_value",  32'(class_value), 32'(exp_c.val));
            end
         end
      end
   end

   task automatic push_beats(input logic [15:0] v3, v2, v1, v0, input int n);
      logic [15:0] v [4];
      v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
      for (int i = 0; i < n; i++) beat_q.push_back('{2'(i), v[i], (i == 3)});
   endtask

   // One full window; the counts are constant across the window.
   task automatic run_window(input logic [15:0] v3, v2, v1, v0,
                             input logic [1:0] ci, input logic [15:0] cv,
                             input int bp_beat, input int bp_cyc, input bit noise);
      acc_values = {v3, v2, v1, v0};
      push_beats(v3, v2, v1, v0, 4);
      class_q.push_back('{ci, cv});
      if (noise) begin
         step = 1; tick(); step = 0;
         chk("idle_step_busy", 32'(busy), 32'd0);
      end
      start = 1; tick(); start = 0;
      chk("clear_pulse",  32'(acc_clear),   32'd1);
      chk("clear_enable", 32'(acc_enable),  32'd0);
      chk("clear_busy",   32'(busy),        32'd1);
      chk("start_zero",   32'(class_value), 32'd0);
      step = noise; tick(); step = 0;
      chk("clear_len", 32'(acc_clear), 32'd0);
      for (int s = 0; s < 3; s++) begin
         chk("accum_enable", 32'(acc_enable), 32'd1);
         start = noise; tick(); start = 0;
         chk("accum_gap_enable", 32'(acc_enable), 32'd1);
         chk("accum_no_restart", 32'(acc_clear),  32'd0);
         step = 1; tick(); step = 0;
         chk("enable_after_step", 32'(acc_enable), (s < 2) ? 32'd1 : 32'd0);
      end
      chk("settle_valid", 32'(out_valid), 32'd0);
      tick();
      chk("readout_valid", 32'(out_valid), 32'd1);
      for (int b = 0; b < 4; b++) begin
         if (b == bp_beat) begin
            out_ready = 0;
            repeat (bp_cyc) tick();
            chk("bp_index", 32'(out_index), 32'(b));
         end
         out_ready = 1;
         step = noise; tick(); step = 0;
      end
      out_ready = 0;
      chk("done_valid", 32'(out_valid), 32'd0);
      chk("done_state", 32'(done),      32'd1);
      tick();
      chk("idle_busy",   32'(busy), 32'd0);
      chk("done_len",    32'(done), 32'd0);
      chk("class_hold",  32'(class_value), 32'(cv));
      chk("beats_left",  32'(beat_q.size()),  32'd0);
      chk("class_left",  32'(class_q.size()), 32'd0);
      tick();
   endtask

   initial begin
      tick();
      chk("reset_outs", 32'({acc_enable, acc_clear, busy, out_valid, out_index, out_value,
                             out_last, class_valid, class_index, class_value, done}), 32'd0);
      rst = 0;
      tick();

      run_window(16'd40, 16'd7,  16'd25, 16'd12, 2'd3, 16'd40, -1, 0, 0); // basic
      run_window(16'd5,  16'd30, 16'd12, 16'd8,  2'd2, 16'd30,  1, 5, 0); // backpressure
      run_window(16'd9,  16'd9,  16'd3,  16'd9,  2'd0, 16'd9,  -1, 0, 1); // tie + ignored inputs

      // Reset during beat 2 of a window.
      acc_values = {16'd11, 16'd22, 16'd33, 16'd44};
      push_beats(16'd11, 16'd22, 16'd33, 16'd44, 2);
      start = 1; tick(); start = 0;
      tick();
      repeat (3) begin step = 1; tick(); step = 0; end
      tick();
      out_ready = 1; tick(); tick();
      out_ready = 0;
      chk("pre_rst_index", 32'(out_index), 32'd2);
      #2 rst = 1;
      #1;
      chk("async_rst_outs", 32'({acc_enable, acc_clear, busy, out_valid, out_index, out_value,
                                 out_last, class_valid, class_index, class_value, done}), 32'd0);
      tick();
      rst = 0;
      repeat (4) tick();
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_beats", 32'(beat_q.size()), 32'd0);
      run_window(16'd100, 16'd200, 16'd300, 16'd50, 2'd1, 16'd300, -1, 0, 0);

      // TIMESTEPS=1 instance.
      b_acc = {16'd3, 16'd9};
      b_start = 1; tick(); b_start = 0;
      chk("t1_clear",      32'(b_clr), 32'd1);
      chk("t1_clear_en",   32'(b_en),  32'd0);
      tick();
      chk("t1_accum_en",   32'(b_en),  32'd1);
      tick();
      chk("t1_wait_en",    32'(b_en),  32'd1);
      b_step = 1; tick(); b_step = 0;
      chk("t1_settle_en",  32'(b_en),    32'd0);
      chk("t1_settle_vld", 32'(b_valid), 32'd0);
      tick();
      chk("t1_beat0", 32'({b_valid, b_idx, b_val, b_last}), 32'({1'b1, 1'b0, 16'd9, 1'b0}));
      b_ready = 1; tick();
      chk("t1_beat1", 32'({b_valid, b_idx, b_val, b_last}), 32'({1'b1, 1'b1, 16'd3, 1'b1}));
      tick(); b_ready = 0;
      chk("t1_done",  32'({b_done, b_cvalid, b_cidx, b_cval, b_valid}),
                      32'({1'b1, 1'b1, 1'b0, 16'd9, 1'b0}));
      tick();
      chk("t1_idle",  32'({b_busy, b_done}), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
